// File: rtl/sm_tx_bit_mapper.sv
// rtl/sm_tx_bit_mapper.sv - serial bits to spatial-modulation symbol indices and PAM-4 levels
// Optional feature macro: SM_TX_GRAY_MAP_EN (Gray pair mapping; natural binary when undefined)
module sm_tx_bit_mapper #(
    parameter int N = 32,
    parameter int Q = 22
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         in_bit,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [4:0]   q_idx,
    output logic [2:0]   m_I_1,
    output logic [2:0]   m_Q_1,
    output logic [2:0]   m_I_2,
    output logic [2:0]   m_Q_2,
    output logic [N-1:0] s_I_1,
    output logic [N-1:0] s_Q_1,
    output logic [N-1:0] s_I_2,
    output logic [N-1:0] s_Q_2
);

    logic [12:0] sr;
    logic [3:0]  cnt;
    logic        full;
    logic        accept;
    logic        last;
    logic        drain_ok;
    logic        load_new;
    logic        load_pend;
    logic        load;
    logic [12:0] frame;
    logic [2:0]  idx_i1, idx_q1, idx_i2, idx_q2;

    function automatic logic [2:0] pair_idx(input logic [1:0] pair);
        logic [2:0] idx;
`ifdef SM_TX_GRAY_MAP_EN
        case (pair)
            2'b00:   idx = 3'd1;
            2'b01:   idx = 3'd2;
            2'b11:   idx = 3'd3;
            default: idx = 3'd4;
        endcase
`else
        idx = {1'b0, pair} + 3'd1;
`endif
        return idx;
    endfunction

    // (2*idx - 5) scaled by 2^Q, two's complement in N bits
    function automatic logic [N-1:0] level(input logic [2:0] idx);
        logic [N-1:0] lv;
        case (idx)
            3'd1:    lv = -(N'(3) << Q);
            3'd2:    lv = -(N'(1) << Q);
            3'd3:    lv = N'(1) << Q;
            3'd4:    lv = N'(3) << Q;
            default: lv = '0;
        endcase
        return lv;
    endfunction

    assign in_ready  = !full;
    assign accept    = in_valid && !full;
    assign last      = accept && (cnt == 4'd12);
    assign drain_ok  = !out_valid || out_ready;
    assign load_new  = last && drain_ok;
    // A pending frame only exists while the output stage is occupied
    assign load_pend = full && out_valid && out_ready;
    assign load      = load_new || load_pend;
    assign frame     = full ? sr : {sr[11:0], in_bit};

    always_comb begin
        idx_i1 = pair_idx(frame[7:6]);
        idx_q1 = pair_idx(frame[5:4]);
        idx_i2 = pair_idx(frame[3:2]);
        idx_q2 = pair_idx(frame[1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            cnt       <= '0;
            full      <= 1'b0;
            out_valid <= 1'b0;
            q_idx     <= '0;
            m_I_1     <= '0;
            m_Q_1     <= '0;
            m_I_2     <= '0;
            m_Q_2     <= '0;
            s_I_1     <= '0;
            s_Q_1     <= '0;
            s_I_2     <= '0;
            s_Q_2     <= '0;
        end else begin
            if (accept) begin
                sr  <= {sr[11:0], in_bit};
                cnt <= (cnt == 4'd12) ? 4'd0 : cnt + 4'd1;
            end

            if (last && !drain_ok)
                full <= 1'b1;
            else if (load_pend)
                full <= 1'b0;

            if (load) begin
                out_valid <= 1'b1;
                q_idx     <= frame[12:8];
                m_I_1     <= idx_i1;
                m_Q_1     <= idx_q1;
                m_I_2     <= idx_i2;
                m_Q_2     <= idx_q2;
                s_I_1     <= level(idx_i1);
                s_Q_1     <= level(idx_q1);
                s_I_2     <= level(idx_i2);
                s_Q_2     <= level(idx_q2);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sm_tx_bit_mapper.sv
// tb/tb_sm_tx_bit_mapper.sv - scoreboard bench for sm_tx_bit_mapper
module tb_sm_tx_bit_mapper;

    localparam int N = 32;
    localparam int Q = 22;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_bit = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [4:0]   q_idx;
    logic [2:0]   m_I_1, m_Q_1, m_I_2, m_Q_2;
    logic [N-1:0] s_I_1, s_Q_1, s_I_2, s_Q_2;

    typedef logic [144:0] vec_t;  // {q, m x4, s x4}

    int     tests = 0;
    int     failed = 0;
    int     cyc = 0;
    vec_t   sb[$];
    int     xfer_cyc[$];

    sm_tx_bit_mapper #(.N(N), .Q(Q)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .q_idx(q_idx),
        .m_I_1(m_I_1), .m_Q_1(m_Q_1), .m_I_2(m_I_2), .m_Q_2(m_Q_2),
        .s_I_1(s_I_1), .s_Q_1(s_Q_1), .s_I_2(s_I_2), .s_Q_2(s_Q_2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t dut_vec();
        return {q_idx, m_I_1, m_Q_1, m_I_2, m_Q_2, s_I_1, s_Q_1, s_I_2, s_Q_2};
    endfunction

    function automatic logic [2:0] ref_idx(input logic [1:0] p);
`ifdef SM_TX_GRAY_MAP_EN
        logic [2:0] t [4] = '{3'd1, 3'd2, 3'd4, 3'd3};
`else
        logic [2:0] t [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
`endif
        return t[p];
    endfunction

    function automatic logic [31:0] ref_lvl(input logic [2:0] i);
        logic [31:0] t [4] = '{32'hFF400000, 32'hFFC00000, 32'h00400000, 32'h00C00000};
        return t[i - 3'd1];
    endfunction

    function automatic vec_t ref_vec(input logic [12:0] f);
        logic [2:0] a, b, c, d;
        a = ref_idx(f[7:6]); b = ref_idx(f[5:4]);
        c = ref_idx(f[3:2]); d = ref_idx(f[1:0]);
        return {f[12:8], a, b, c, d, ref_lvl(a), ref_lvl(b), ref_lvl(c), ref_lvl(d)};
    endfunction

    task automatic cmp(input string name, input vec_t act, input vec_t exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                cmp("unexpected_vector", dut_vec(), '0);
                if (dut_vec() == '0) begin
                    failed++;
                    $display("[TB] FAIL unexpected_vector actual=valid required=none");
                end
            end else begin
                cmp("scoreboard", dut_vec(), sb.pop_front());
            end
            xfer_cyc.push_back(cyc);
        end
    end

    task automatic send_bit(input logic b);
        int n = 0;
        in_valid = 1'b1;
        in_bit   = b;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) cmp("send_timeout", 145'd0, 145'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [12:0] f, input bit gaps);
        for (int i = 12; i >= 0; i--) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send_bit(f[i]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    localparam logic [12:0] F_PLAN = 13'b1011000011110;
`ifdef SM_TX_GRAY_MAP_EN
    localparam vec_t V_PLAN = {5'd22, 3'd1, 3'd2, 3'd3, 3'd4,
                               32'hFF400000, 32'hFFC00000, 32'h00400000, 32'h00C00000};
`else
    localparam vec_t V_PLAN = {5'd22, 3'd1, 3'd2, 3'd4, 3'd3,
                               32'hFF400000, 32'hFFC00000, 32'h00C00000, 32'h00400000};
`endif
    localparam logic [12:0] F_A = 13'b0000111100101;
    localparam logic [12:0] F_B = 13'b1111000011011;
    localparam logic [12:0] F_C = 13'b0101010100110;

    initial begin
        logic [12:0] rf [10];
        vec_t        va;
        vec_t        vb;

        #1;
        cmp("reset_state", {dut_vec(), out_valid, in_ready}, {145'd0, 1'b0, 1'b1});
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Test-plan frame: out_valid must rise exactly on the 13th-bit edge
        out_ready = 1'b1;
        sb.push_back(V_PLAN);
        for (int i = 12; i >= 1; i--) send_bit(F_PLAN[i]);
        cmp("latency_before", {144'd0, out_valid}, 145'd0);
        send_bit(F_PLAN[0]);
        cmp("latency_after", {144'd0, out_valid}, 145'd1);
        cmp("plan_vector", dut_vec(), V_PLAN);
        idle(3);

        // In-frame gaps must give the same vector
        sb.push_back(V_PLAN);
        send_frame(F_PLAN, 1'b1);
        idle(3);

        // Backpressure: second frame waits, first vector holds
        out_ready = 1'b0;
        va = ref_vec(F_A);
        vb = ref_vec(F_B);
        sb.push_back(va);
        sb.push_back(vb);
        send_frame(F_A, 1'b0);
        cmp("bp_valid", {144'd0, out_valid}, 145'd1);
        for (int i = 12; i >= 0; i--) begin
            send_bit(F_B[i]);
            cmp("bp_hold", dut_vec(), va);
        end
        cmp("bp_in_ready_low", {144'd0, in_ready}, 145'd0);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        idle(3);
        in_valid = 1'b0;
        cmp("bp_still_held", dut_vec(), va);
        out_ready = 1'b1;
        idle(1);
        cmp("bp_second_valid_ready", {143'd0, out_valid, in_ready}, {143'd0, 1'b1, 1'b1});
        cmp("bp_second_vector", dut_vec(), vb);
        idle(2);
        cmp("bp_drained", {144'd0, out_valid}, 145'd0);
        sb.push_back(ref_vec(F_C));
        send_frame(F_C, 1'b0);
        idle(3);

        // Continuous stream of 130 bits: 10 vectors, 13 cycles apart
        for (int k = 0; k < 10; k++) rf[k] = 13'($urandom);
        xfer_cyc.delete();
        for (int k = 0; k < 10; k++) begin
            sb.push_back(ref_vec(rf[k]));
            send_frame(rf[k], 1'b0);
        end
        idle(4);
        cmp("stream_count", 145'(xfer_cyc.size()), 145'd10);
        for (int k = 1; k < xfer_cyc.size(); k++)
            cmp("stream_spacing", 145'(xfer_cyc[k] - xfer_cyc[k-1]), 145'd13);

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        cmp("reset_mid_outputs", {dut_vec(), out_valid, in_ready}, {145'd0, 1'b0, 1'b1});
        idle(2);
        cmp("reset_hold_outputs", {dut_vec(), out_valid}, {145'd0, 1'b0});
        rst_n = 1'b1;
        xfer_cyc.delete();
        idle(1);
        sb.push_back(V_PLAN);
        send_frame(F_PLAN, 1'b0);
        idle(20);
        cmp("reset_one_vector", 145'(xfer_cyc.size()), 145'd1);
        cmp("scoreboard_empty", 145'(sb.size()), 145'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
